seq_pattern_detector: RTL and testbench
=======================================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 16: match-counter width.
REQ-003 SHALL have parameter LEN_W, default $clog2(PAT_W+1): length-field width.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-low reset.
REQ-006 i_valid  in  1  qualifies i_a; i_a is ignored when low.
REQ-007 i_a  in  1  serial input bit.
REQ-008 i_cfg_load  in  1  one-cycle strobe latching pattern, length and mode.
REQ-009 i_cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit to arrive, bit 0 the last.
REQ-010 i_cfg_len  in  LEN_W  pattern length in bits.
REQ-011 i_cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 i_clr_count  in  1  synchronous clear of the match counter.
REQ-013 o_detect  out  1  registered one-cycle match pulse.
REQ-014 o_match_count  out  CNT_W  saturating match count.
REQ-015 o_cfg_err  out  1  active configuration is invalid.

Function
REQ-016 SHALL keep a PAT_W-bit history shift register; each accepted bit (i_valid=1) shifts in at bit 0.
REQ-017 SHALL keep a fill counter of accepted bits since the last flush, saturating at len.
REQ-018 SHALL implement an FSM with states FILL, ARMED, ERR.
- FILL: fill count < len.
- ARMED: fill count == len.
- ERR: configured length is invalid.
REQ-019 Match SHALL be declared when an accepted bit leaves the post-shift history low len bits equal to pattern low len bits, and fill count (including this bit) >= len.
REQ-020 o_detect SHALL go high the cycle after the rising edge that samples the completing bit, for exactly one cycle.
REQ-021 Overlap mode SHALL keep history and fill count after a match.
REQ-022 Non-overlap mode SHALL zero the fill count on a match; the FSM returns to FILL.
REQ-023 Cycles with i_valid=0 SHALL leave history, fill count, FSM state and o_detect=0 unchanged.
REQ-024 i_cfg_load SHALL latch pattern, len and overlap, zero the fill count and enter FILL, or ERR if invalid.
REQ-025 The bit offered in the same cycle as i_cfg_load SHALL be discarded.
REQ-026 Length SHALL be invalid if len < 2 or len > PAT_W; in ERR, o_cfg_err=1 and no detection occurs.
REQ-027 Any subsequent valid load SHALL exit ERR.
REQ-028 o_match_count SHALL increment with each o_detect and saturate at 2^CNT_W-1.
REQ-029 i_clr_count with a simultaneous match SHALL set the count to 1; otherwise the count becomes 0.

Reset
REQ-030 While i_rst=0, outputs SHALL be o_detect=0, o_match_count=0, o_cfg_err=0.
REQ-031 Reset SHALL zero history and fill count and set the FSM to FILL.
REQ-032 Reset SHALL load the default configuration: pattern 110, len=3, overlap=1.
REQ-033 Reset asserted mid-sequence SHALL discard partial matches; no detect is issued from pre-reset bits.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef and the reset-default pattern, length and overlap constants.
REQ-035 The saturating match counter SHALL be one sub-module, sat_counter (params WIDTH; inputs inc, clr).

Verification
REQ-036 Reset then default config, stream 1,1,0,1,1,0 -> o_detect pulses after bits 3 and 6; count=2.
REQ-037 Load 1010, len=4, overlap=1, stream 1,0,1,0,1,0 -> detects after bits 4 and 6.
REQ-038 Same load with overlap=0 -> detect after bit 4 only; count=1.
REQ-039 Default config, stream 1,1,0 with i_valid=0 gaps of 3 cycles between bits -> exactly one detect after the third accepted bit.
REQ-040 Load len=0, and separately len=PAT_W+1 -> o_cfg_err=1, no detect on stream 110110.
REQ-041 Load len=0, then load a valid config -> o_cfg_err clears.
REQ-042 CNT_W=2, five matches -> count saturates at 3.
REQ-043 Assert i_clr_count on the match cycle -> count=1.
REQ-044 Reset asserted after bits 1,1, then bit 0 after release -> no detect.

Source files
------------

// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and reset-default configuration for the serial pattern detector.
package seq_pattern_detector_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    localparam logic [31:0] DEF_PATTERN = 32'b110;
    localparam int unsigned DEF_LEN     = 3;
    localparam logic        DEF_OVERLAP = 1'b1;

    function automatic logic len_is_valid(input int unsigned len, input int unsigned pat_w);
        return (len >= 2) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coinciding with an increment leaves the count at one.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? WIDTH'(1) : '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with run-time pattern/length/overlap configuration
// and a saturating match counter.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_a,
    input  logic             i_cfg_load,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_cfg_overlap,
    input  logic             i_clr_count,
    output logic             o_detect,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_cfg_err
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             detect_q, detect_d;

    logic [PAT_W-1:0] hist_shift;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_inc;
    logic             hit;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    // Candidate view of the datapath if the offered bit is accepted this cycle.
    always_comb begin
        hist_shift = (hist_q << 1) | PAT_W'(i_a);
        fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        hit        = (((hist_shift ^ pat_q) & len_mask) == '0) && (fill_inc == len_q);
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        detect_d = 1'b0;

        if (i_cfg_load) begin
            // The bit offered alongside a load is dropped; matching restarts from empty.
            pat_d   = i_cfg_pattern;
            len_d   = i_cfg_len;
            ovl_d   = i_cfg_overlap;
            fill_d  = '0;
            state_d = len_is_valid(32'(i_cfg_len), PAT_W) ? ST_FILL : ST_ERR;
        end else begin
            case (state_q)
                ST_FILL, ST_ARMED: begin
                    if (i_valid) begin
                        hist_d = hist_shift;
                        if (hit) begin
                            detect_d = 1'b1;
                            if (ovl_q) begin
                                fill_d  = fill_inc;
                                state_d = ST_ARMED;
                            end else begin
                                fill_d  = '0;
                                state_d = ST_FILL;
                            end
                        end else begin
                            fill_d  = fill_inc;
                            state_d = (fill_inc == len_q) ? ST_ARMED : ST_FILL;
                        end
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_FILL;
            hist_q   <= '0;
            fill_q   <= '0;
            pat_q    <= DEF_PATTERN[PAT_W-1:0];
            len_q    <= LEN_W'(DEF_LEN);
            ovl_q    <= DEF_OVERLAP;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            detect_q <= detect_d;
        end
    end

    // Counter advances on the same edge that raises o_detect.
    sat_counter #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .clk   (i_clk),
        .rst_n (i_rst),
        .inc   (detect_d),
        .clr   (i_clr_count),
        .count (o_match_count)
    );

    assign o_detect  = detect_q;
    assign o_cfg_err = (state_q == ST_ERR);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench: driver pushes expected outputs from a bit-list reference model,
// monitor pops and compares one cycle later. A second DUT with a 2-bit counter runs in parallel.
module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 16;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             i_a;
    logic             i_cfg_load;
    logic [PAT_W-1:0] i_cfg_pattern;
    logic [LEN_W-1:0] i_cfg_len;
    logic             i_cfg_overlap;
    logic             i_clr_count;

    logic             det1, err1;
    logic [CNT_W-1:0] cnt1;
    logic             det2, err2;
    logic [1:0]       cnt2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_valid(i_valid), .i_a(i_a),
        .i_cfg_load(i_cfg_load), .i_cfg_pattern(i_cfg_pattern), .i_cfg_len(i_cfg_len),
        .i_cfg_overlap(i_cfg_overlap), .i_clr_count(i_clr_count),
        .o_detect(det1), .o_match_count(cnt1), .o_cfg_err(err1)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(i_valid), .i_a(i_a),
        .i_cfg_load(i_cfg_load), .i_cfg_pattern(i_cfg_pattern), .i_cfg_len(i_cfg_len),
        .i_cfg_overlap(i_cfg_overlap), .i_clr_count(i_clr_count),
        .o_detect(det2), .o_match_count(cnt2), .o_cfg_err(err2)
    );

    typedef struct {
        int due;
        bit det;
        int cnt;
        int cnt2;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the accepted bits since the last flush, oldest first.
    bit               bits[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_err;
    int               m_cnt;
    int               m_cnt2;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        m_pat  = PAT_W'(3'b110);
        m_len  = 3;
        m_ovl  = 1'b1;
        m_err  = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic set_idle();
        i_valid = 0; i_a = 0; i_cfg_load = 0; i_cfg_pattern = '0;
        i_cfg_len = '0; i_cfg_overlap = 0; i_clr_count = 0;
    endtask

    task automatic drive(input bit v, input bit a, input bit ld, input logic [PAT_W-1:0] p,
                         input int len, input bit ovl, input bit clr);
        exp_t e;
        bit   det;
        @(negedge clk);
        i_valid = v; i_a = a; i_cfg_load = ld; i_cfg_pattern = p;
        i_cfg_len = LEN_W'(len); i_cfg_overlap = ovl; i_clr_count = clr;
        det = 0;
        if (ld) begin
            m_pat = p; m_len = len; m_ovl = ovl;
            m_err = (len < 2) || (len > PAT_W);
            bits.delete();
        end else if (v && !m_err) begin
            bits.push_back(a);
            while (bits.size() > m_len) void'(bits.pop_front());
            if (bits.size() == m_len) begin
                det = 1;
                for (int k = 0; k < m_len; k++)
                    if (bits[k] != m_pat[m_len-1-k]) det = 0;
            end
            if (det && !m_ovl) bits.delete();
        end
        if (clr) begin
            m_cnt  = det;
            m_cnt2 = det;
        end else if (det) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        e.due = cyc + 1; e.det = det; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic bit_in(input bit a);
        drive(1, a, 0, '0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int len, input bit ovl);
        drive(0, 0, 1, p, len, ovl, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_detect", det1, 0);
        check("rst_count", cnt1, 0);
        check("rst_cfg_err", err1, 0);
        check("rst_detect2", det2, 0);
        check("rst_count2", cnt2, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        #2;
        exp_q.delete();
        rst_n = 0;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
    endtask

    // Monitor: compares whatever the DUTs present against the entry due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                check("stale_entry", 0, 1);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("detect", det1, e.det);
                check("count", cnt1, e.cnt);
                check("cfg_err", err1, e.err);
                check("detect_w2", det2, e.det);
                check("count_w2", cnt2, e.cnt2);
                check("cfg_err_w2", err2, e.err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        set_idle();
        rst_n = 0;
        model_reset();
        #3;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 rst_n = 1;

        // default 110 overlapping
        bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
        idle(2);

        // 1010 overlap, then non-overlap
        load(PAT_W'(4'b1010), 4, 1);
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        drive(0, 0, 0, '0, 0, 0, 1);
        load(PAT_W'(4'b1010), 4, 0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0);

        // default config with valid gaps
        do_reset();
        bit_in(1); idle(3); bit_in(1); idle(3); bit_in(0); idle(3);

        // invalid lengths, then recovery
        load(PAT_W'(3'b110), 0, 1);
        bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
        load(PAT_W'(3'b110), PAT_W + 1, 1);
        bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
        load(PAT_W'(3'b110), 0, 1);
        load(PAT_W'(3'b110), 3, 1);
        idle(1);

        // saturation of the narrow counter, then clear on a match cycle
        for (int i = 0; i < 5; i++) begin bit_in(1); bit_in(1); bit_in(0); end
        bit_in(1); bit_in(1); drive(1, 0, 0, '0, 0, 0, 1);
        bit_in(1); bit_in(1); drive(1, 0, 0, '0, 0, 0, 1);
        drive(1, 1, 0, '0, 0, 0, 1);

        // bit offered with a load is discarded
        drive(1, 1, 1, PAT_W'(2'b11), 2, 1, 0);
        bit_in(1); bit_in(1); bit_in(1);

        // reset mid-sequence
        load(PAT_W'(3'b110), 3, 1);
        bit_in(1); bit_in(1);
        do_reset();
        bit_in(0); idle(2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset();
            end else if (r < 25) begin
                int len;
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, PAT_W + 1) : $urandom_range(2, 4);
                load(PAT_W'($urandom), len, $urandom_range(0, 1));
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 0, '0, 0, 0,
                      $urandom_range(0, 39) == 0);
            end
        end

        idle(2);
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #1;
        if (exp_q.size() > 0) check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
